// File: rtl/gmii_tx_drain.sv
// gmii_tx_drain: frame-aware drain from a show-ahead TX FIFO onto GMII.
// Starts a frame on fill threshold or a fully buffered frame, enforces the IFG, and turns underrun into an errored, dropped frame.
//
// state | meaning
// IDLE  | waiting for port_en and a buffered frame or enough fill
// SEND  | popping words onto GMII, one per cycle
// DROP  | discarding the rest of an underrun frame up to its eop
// IFG   | inter-frame gap countdown
module gmii_tx_drain #(
    parameter int DATA_WIDTH      = 8,
    parameter int USEDW_WIDTH     = 8,
    parameter int START_THRESHOLD = 4,
    parameter int IFG_CYCLES      = 11,
    parameter int FCNT_WIDTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    port_en,
    input  logic [USEDW_WIDTH-1:0]  fifo_usedw,
    input  logic                    fifo_empty,
    input  logic [DATA_WIDTH+1:0]   fifo_rdata,
    input  logic                    fifo_frame_wr,
    output logic                    fifo_rdreq,
    output logic                    gmii_tx_en,
    output logic                    gmii_tx_er,
    output logic [DATA_WIDTH-1:0]   gmii_txd,
    output logic [15:0]             underrun_cnt,
    output logic [31:0]             tx_frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2,
        IFG  = 2'd3
    } state_t;

    // IFG_CYCLES is expected to be at least 1; the counter runs IFG_CYCLES-1 down to 0.
    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES - 1);

    state_t                 state;
    logic [FCNT_WIDTH-1:0]  fcnt;
    logic [IFG_W-1:0]       ifg_cnt;
    logic                   pop;
    logic                   pop_eop;
    logic                   start_ok;

    assign pop        = ((state == SEND) || (state == DROP)) && !fifo_empty;
    assign fifo_rdreq = pop;
    assign pop_eop    = pop && fifo_rdata[DATA_WIDTH+1];

    // The eop write pulse counts as a buffered frame in the same cycle so short frames start promptly.
    assign start_ok = port_en && ((fcnt != '0) || fifo_frame_wr ||
                                  (fifo_usedw >= USEDW_WIDTH'(START_THRESHOLD)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
        end else if (fifo_frame_wr && !pop_eop && (fcnt != '1)) begin
            fcnt <= fcnt + 1'b1;
        end else if (pop_eop && !fifo_frame_wr && (fcnt != '0)) begin
            fcnt <= fcnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ifg_cnt      <= '0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            gmii_txd     <= '0;
            underrun_cnt <= '0;
            tx_frame_cnt <= '0;
        end else begin
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            gmii_txd   <= '0;
            case (state)
                IDLE: begin
                    if (start_ok) state <= SEND;
                end
                SEND: begin
                    if (!fifo_empty) begin
                        gmii_tx_en <= 1'b1;
                        gmii_tx_er <= fifo_rdata[DATA_WIDTH];
                        gmii_txd   <= fifo_rdata[DATA_WIDTH-1:0];
                        if (fifo_rdata[DATA_WIDTH+1]) begin
                            tx_frame_cnt <= tx_frame_cnt + 32'd1;
                            ifg_cnt      <= IFG_LOAD;
                            state        <= IFG;
                        end
                    end else begin
                        // underrun: one errored byte, then discard the remainder
                        gmii_tx_en <= 1'b1;
                        gmii_tx_er <= 1'b1;
                        if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 16'd1;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (pop_eop) begin
                        ifg_cnt <= IFG_LOAD;
                        state   <= IFG;
                    end
                end
                IFG: begin
                    if (ifg_cnt == '0) state <= IDLE;
                    else               ifg_cnt <= ifg_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_drain.sv
// tb_gmii_tx_drain: bench FIFO + writer model feeding gmii_tx_drain; expected GMII bytes are
// queued when frames are written and a negedge monitor pops and compares them.
module tb_gmii_tx_drain;

    localparam int IFG = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        port_en = 1'b0;
    logic [7:0]  fifo_usedw;
    logic        fifo_empty;
    logic [9:0]  fifo_rdata;
    logic        fifo_frame_wr = 1'b0;
    logic        fifo_rdreq;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic [7:0]  gmii_txd;
    logic [15:0] underrun_cnt;
    logic [31:0] tx_frame_cnt;

    gmii_tx_drain #(
        .DATA_WIDTH(8), .USEDW_WIDTH(8), .START_THRESHOLD(4), .IFG_CYCLES(IFG), .FCNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .port_en(port_en),
        .fifo_usedw(fifo_usedw), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_frame_wr(fifo_frame_wr), .fifo_rdreq(fifo_rdreq),
        .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .gmii_txd(gmii_txd),
        .underrun_cnt(underrun_cnt), .tx_frame_cnt(tx_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0]  fifo_q[$];   // {eop, er, data}
    logic [10:0] wr_q[$];     // {valid, eop, er, data}; valid=0 is an idle writer cycle
    logic [9:0]  exp_q[$];    // {last, er, data}
    bit rdreq_s = 1'b0;
    bit rand_en = 1'b0;
    int exp_frames = 0;
    int exp_underruns = 0;
    int wr_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic update_pins();
        fifo_empty = (fifo_q.size() == 0);
        fifo_usedw = (fifo_q.size() > 255) ? 8'hFF : 8'(fifo_q.size());
        fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 10'h0;
    endtask

    always @(negedge clk) rdreq_s <= fifo_rdreq;

    // One clock: apply the pop the DUT requested at this edge, then the writer's word for the cycle.
    task automatic step();
        logic [10:0] w;
        @(posedge clk);
        #1;
        fifo_frame_wr = 1'b0;
        if (rand_en) port_en = ($urandom_range(0, 9) != 0);
        if (rdreq_s) begin
            n_checks++;
            if (fifo_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_on_empty: rdreq=1, FIFO holds 0 words, required rdreq=0");
            end else begin
                void'(fifo_q.pop_front());
            end
        end
        if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            if (w[10]) begin
                fifo_q.push_back(w[9:0]);
                if (w[9]) begin
                    fifo_frame_wr = 1'b1;
                    wr_cyc = cyc;
                end
            end
        end
        update_pins();
    endtask

    task automatic queue_frame(input int len, input bit rnd, input int gap);
        logic [7:0] d;
        logic       er;
        logic       last;
        for (int i = 0; i < gap; i++) wr_q.push_back(11'h0);
        for (int i = 0; i < len; i++) begin
            d    = rnd ? 8'($urandom) : 8'(i);
            er   = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
            last = (i == len - 1);
            wr_q.push_back({1'b1, last, er, d});
            exp_q.push_back({last, er, d});
        end
        exp_frames++;
    endtask

    task automatic wait_drain();
        int n = 0;
        rand_en = 1'b0;
        port_en = 1'b1;
        while ((wr_q.size() != 0 || fifo_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= 3000) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles, required 0", exp_q.size(), n);
        end
        repeat (IFG + 4) step();
    endtask

    // Monitor: compare each GMII byte with the scoreboard, check idle pins, contiguity and gaps.
    bit         prev_en = 1'b0;
    bit         prev_last = 1'b0;
    bit         have_prev = 1'b0;
    int         idle_run = 0;
    int         last_gap = -1;
    int         first_cyc = 0;
    int         bytes_seen = 0;
    logic [9:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en   = 1'b0;
            prev_last = 1'b0;
            have_prev = 1'b0;
            idle_run  = 0;
        end else if (gmii_tx_en) begin
            if (!prev_en) begin
                first_cyc = cyc;
                last_gap  = idle_run;
                if (have_prev) begin
                    n_checks++;
                    if (idle_run < IFG + 1) begin
                        n_fail++;
                        $display("FAIL ifg_gap: %0d idle cycles, required at least %0d", idle_run, IFG + 1);
                    end
                end
            end else begin
                check("no_gap_after_eop", prev_last, 1'b0);
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: er=%0b txd=0x%0h, required idle", gmii_tx_er, gmii_txd);
                prev_last = 1'b1;
            end else begin
                e = exp_q.pop_front();
                check("gmii_byte", {gmii_tx_er, gmii_txd}, e[8:0]);
                prev_last = e[9];
            end
            bytes_seen++;
            idle_run = 0;
            prev_en  = 1'b1;
        end else begin
            check("idle_pins", {gmii_tx_er, gmii_txd}, 9'h0);
            if (prev_en) begin
                check("frame_end_at_eop", prev_last, 1'b1);
                have_prev = 1'b1;
            end
            idle_run++;
            prev_en = 1'b0;
        end
    end

    task automatic wait_bytes(input int n);
        int k = 0;
        while (bytes_seen < n && k < 1000) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= 1000) begin
            n_fail++;
            $display("FAIL byte_wait_timeout: %0d bytes seen, required %0d", bytes_seen, n);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_tx_frame_cnt"}, tx_frame_cnt, exp_frames);
        check({tag, "_underrun_cnt"}, underrun_cnt, exp_underruns);
        check({tag, "_fcnt"}, dut.fcnt, 8'h0);
    endtask

    initial begin
        int base;
        int k;
        update_pins();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_en", gmii_tx_en, 1'b0);
        check("rst_tx_er", gmii_tx_er, 1'b0);
        check("rst_txd", gmii_txd, 8'h0);
        check("rst_rdreq", fifo_rdreq, 1'b0);
        check_counters("rst");
        rst_n   = 1'b1;
        port_en = 1'b1;
        repeat (3) step();

        // 64-byte frame 0x00..0x3F
        queue_frame(64, 1'b0, 0);
        wait_drain();
        check_counters("frame64");

        // 3-byte frame below threshold: first byte two cycles after the eop write
        queue_frame(3, 1'b0, 0);
        wait_drain();
        check("short_start_latency", first_cyc - wr_cyc, 2);
        check_counters("short");

        // two pre-buffered 60-byte frames: gap must be exactly IFG+1
        base = exp_frames;
        port_en = 1'b0;
        queue_frame(60, 1'b1, 0);
        queue_frame(60, 1'b1, 0);
        k = 0;
        while (wr_q.size() != 0 && k < 500) begin
            step();
            k++;
        end
        wait_drain();
        check("b2b_gap", last_gap, IFG + 1);
        check("b2b_frames", tx_frame_cnt - base, 2);
        check_counters("b2b");

        // underrun: 10 bytes, writer stalls, 5 late bytes with eop are dropped
        for (int i = 0; i < 10; i++) begin
            wr_q.push_back({1'b1, 1'b0, 1'b0, 8'(8'h40 + i)});
            exp_q.push_back({1'b0, 1'b0, 8'(8'h40 + i)});
        end
        exp_q.push_back({1'b1, 1'b1, 8'h00});
        exp_underruns++;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            step();
            k++;
        end
        check("underrun_seen", exp_q.size(), 0);
        repeat (5) step();
        for (int i = 0; i < 5; i++) wr_q.push_back({1'b1, (i == 4), 1'b0, 8'(8'h80 + i)});
        wait_drain();
        check_counters("underrun");

        // port_en dropped mid-frame: frame completes, next one waits
        base = bytes_seen;
        queue_frame(30, 1'b1, 0);
        queue_frame(10, 1'b1, 0);
        wait_bytes(base + 10);
        port_en = 1'b0;
        repeat (80) step();
        check("held_frame_pending", exp_q.size(), 10);
        check("held_frame_count", tx_frame_cnt, exp_frames - 1);
        port_en = 1'b1;
        wait_drain();
        check_counters("port_en");

        // randomized traffic with random writer gaps and port_en toggling
        rand_en = 1'b1;
        for (int f = 0; f < 40; f++) queue_frame($urandom_range(1, 24), 1'b1, $urandom_range(0, 15));
        k = 0;
        while (wr_q.size() != 0 && k < 3000) begin
            step();
            k++;
        end
        wait_drain();
        check_counters("random");

        // asynchronous reset at byte 20 of a 64-byte frame
        base = bytes_seen;
        queue_frame(64, 1'b0, 0);
        wait_bytes(base + 20);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx_en", gmii_tx_en, 1'b0);
        check("async_rst_tx_er", gmii_tx_er, 1'b0);
        check("async_rst_txd", gmii_txd, 8'h0);
        check("async_rst_rdreq", fifo_rdreq, 1'b0);
        fifo_q.delete();
        wr_q.delete();
        exp_q.delete();
        exp_frames = 0;
        exp_underruns = 0;
        rdreq_s = 1'b0;
        fifo_frame_wr = 1'b0;
        update_pins();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_rdreq", fifo_rdreq, 1'b0);
        check("post_rst_tx_en", gmii_tx_en, 1'b0);
        check_counters("post_rst");

        // frame after reset goes through normally
        queue_frame(8, 1'b1, 0);
        wait_drain();
        check_counters("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
